// File: rtl/sram_like_arbiter_if.sv
// sram-like request/response bundle shared by both cache miss paths and the
// downstream memory port. The requester side uses the master modport, the
// side that services requests uses the slave modport.
interface sram_like_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  addr_ok;
    logic                  data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-into-one sram-like arbiter: the instruction and data miss paths share a
// single downstream memory port with one transaction outstanding at a time.
// Grants are registered (one bubble cycle from req to mem_req), so there is
// no combinational path from any requester req to mem_req.
module sram_like_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master mem
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    state_t state_q, state_d;
    grant_t last_grant_q, last_grant_d;
    // Set when the granted requester withdrew its req before addr_ok; the
    // downstream handshake is still finished but its result is dropped.
    logic   discard_q, discard_d;

    // View of whichever requester currently owns the memory port.
    logic                  sel_data;
    logic                  sel_req;
    logic                  sel_wr;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Unsplit response strobes, steered to the owning side below.
    logic                  mem_req_c;
    logic                  mem_wr_c;
    logic [1:0]            mem_size_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic                  addr_ok_c;
    logic                  data_ok_c;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic                  lost;

    // State, grant history and discard flag; reset parks in IDLE with the
    // last grant marked as INST so the very first tie goes to the data side.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_INST;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            discard_q    <= discard_d;
        end
    end

    // Pick the owning requester's request fields for the downstream port.
    always_comb begin
        sel_data  = (state_q == D_ADDR) || (state_q == D_DATA);
        sel_req   = sel_data ? data.req   : inst.req;
        sel_wr    = sel_data ? data.wr    : inst.wr;
        sel_size  = sel_data ? data.size  : inst.size;
        sel_addr  = sel_data ? data.addr  : inst.addr;
        sel_wdata = sel_data ? data.wdata : inst.wdata;
    end

    // Next-state and output logic: arbitration in IDLE, address and data
    // phases of the granted transaction otherwise.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        discard_d    = discard_q;
        mem_req_c    = 1'b0;
        mem_wr_c     = 1'b0;
        mem_size_c   = 2'd0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        addr_ok_c    = 1'b0;
        data_ok_c    = 1'b0;
        rdata_c      = '0;
        lost         = discard_q | ~sel_req;

        unique case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (inst.req && data.req) begin
                    // Tie: alternate when round-robin is on, else data wins.
                    if (RR_EN && (last_grant_q == GRANT_DATA)) begin
                        state_d      = I_ADDR;
                        last_grant_d = GRANT_INST;
                    end else begin
                        state_d      = D_ADDR;
                        last_grant_d = GRANT_DATA;
                    end
                end else if (data.req) begin
                    state_d      = D_ADDR;
                    last_grant_d = GRANT_DATA;
                end else if (inst.req) begin
                    state_d      = I_ADDR;
                    last_grant_d = GRANT_INST;
                end
            end

            I_ADDR, D_ADDR: begin
                mem_req_c   = 1'b1;
                mem_wr_c    = sel_wr;
                mem_size_c  = sel_size;
                mem_addr_c  = sel_addr;
                mem_wdata_c = sel_wdata;
                discard_d   = lost;
                if (mem.addr_ok) begin
                    addr_ok_c = ~lost;
                    if (mem.data_ok) begin
                        // Accepted and completed in the same cycle.
                        data_ok_c = ~lost;
                        rdata_c   = lost ? '0 : mem.rdata;
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = sel_data ? D_DATA : I_DATA;
                    end
                end
                // A data_ok without addr_ok here is stale and ignored.
            end

            I_DATA, D_DATA: begin
                if (mem.data_ok) begin
                    data_ok_c = ~discard_q;
                    rdata_c   = discard_q ? '0 : mem.rdata;
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Downstream request fields.
    assign mem.req   = mem_req_c;
    assign mem.wr    = mem_wr_c;
    assign mem.size  = mem_size_c;
    assign mem.addr  = mem_addr_c;
    assign mem.wdata = mem_wdata_c;

    // Responses go only to the owning side; the other side sees zeros.
    assign inst.addr_ok = addr_ok_c & ~sel_data;
    assign inst.data_ok = data_ok_c & ~sel_data;
    assign inst.rdata   = (data_ok_c && !sel_data) ? rdata_c : '0;
    assign data.addr_ok = addr_ok_c & sel_data;
    assign data.data_ok = data_ok_c & sel_data;
    assign data.rdata   = (data_ok_c && sel_data) ? rdata_c : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the arbiter.
module tb_sram_like_arbiter;

    localparam bit RR = 1'b1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ib ();
    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) db ();
    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mb ();
    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fi ();
    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fd ();
    sram_like_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fm ();

    sram_like_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(RR)) dut (
        .clk    (clk),
        .resetn (resetn),
        .inst   (ib),
        .data   (db),
        .mem    (mb)
    );

    sram_like_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1'b0)) u_fixed (
        .clk    (clk),
        .resetn (resetn),
        .inst   (fi),
        .data   (fd),
        .mem    (fm)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Transaction-level model: who owns the port (0 none, 1 inst, 2 data),
    // whether that transaction still waits for acceptance, and who won last.
    int m_owner = 0;
    bit m_wait  = 1'b0;
    int m_last  = 1;

    logic        e_mreq, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic        e_i_aok, e_i_dok, e_d_aok, e_d_dok;
    logic [31:0] e_i_rd, e_d_rd;
    logic        pv_i_aok = 1'b0;
    logic        pv_d_aok = 1'b0;

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        #1;
        if (!resetn) begin
            m_owner = 0;
            m_wait  = 1'b0;
            m_last  = 1;
        end
        e_mreq = 0; e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
        e_i_aok = 0; e_i_dok = 0; e_i_rd = 0;
        e_d_aok = 0; e_d_dok = 0; e_d_rd = 0;
        if (m_owner != 0) begin
            logic aok, dok;
            aok = 0;
            dok = 0;
            if (m_wait) begin
                e_mreq  = 1;
                e_wr    = (m_owner == 1) ? ib.wr    : db.wr;
                e_size  = (m_owner == 1) ? ib.size  : db.size;
                e_addr  = (m_owner == 1) ? ib.addr  : db.addr;
                e_wdata = (m_owner == 1) ? ib.wdata : db.wdata;
                aok = mb.addr_ok;
                dok = mb.addr_ok && mb.data_ok;
            end else begin
                dok = mb.data_ok;
            end
            if (m_owner == 1) begin
                e_i_aok = aok; e_i_dok = dok; e_i_rd = dok ? mb.rdata : 32'h0;
            end else begin
                e_d_aok = aok; e_d_dok = dok; e_d_rd = dok ? mb.rdata : 32'h0;
            end
        end
        check("mem_req",      mb.req,      e_mreq);
        check("mem_wr",       mb.wr,       e_wr);
        check("mem_size",     mb.size,     e_size);
        check("mem_addr",     mb.addr,     e_addr);
        check("mem_wdata",    mb.wdata,    e_wdata);
        check("inst_addr_ok", ib.addr_ok,  e_i_aok);
        check("inst_data_ok", ib.data_ok,  e_i_dok);
        check("inst_rdata",   ib.rdata,    e_i_rd);
        check("data_addr_ok", db.addr_ok,  e_d_aok);
        check("data_data_ok", db.data_ok,  e_d_dok);
        check("data_rdata",   db.rdata,    e_d_rd);
        pv_i_aok = e_i_aok;
        pv_d_aok = e_d_aok;
        if (resetn) begin
            if (m_owner == 0) begin
                int pick;
                pick = 0;
                if (ib.req && db.req) pick = RR ? ((m_last == 1) ? 2 : 1) : 2;
                else if (db.req)      pick = 2;
                else if (ib.req)      pick = 1;
                if (pick != 0) begin
                    m_owner = pick;
                    m_wait  = 1'b1;
                    m_last  = pick;
                end
            end else if (m_wait) begin
                if (mb.addr_ok) begin
                    if (mb.data_ok) m_owner = 0;
                    else            m_wait  = 1'b0;
                end
            end else if (mb.data_ok) begin
                m_owner = 0;
            end
        end
    end

    task automatic clear_main();
        ib.req = 0; ib.wr = 0; ib.size = 0; ib.addr = 0; ib.wdata = 0;
        db.req = 0; db.wr = 0; db.size = 0; db.addr = 0; db.wdata = 0;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 0;
    endtask

    // Fixed-priority instance: data wins every tie; inst only once data drops.
    initial begin
        int ng, nd;
        logic [31:0] first;
        fi.req = 0; fi.wr = 0; fi.size = 0; fi.addr = 0; fi.wdata = 0;
        fd.req = 0; fd.wr = 0; fd.size = 0; fd.addr = 0; fd.wdata = 0;
        fm.addr_ok = 0; fm.data_ok = 0; fm.rdata = 0;
        ng = 0; nd = 0; first = 0;
        @(posedge resetn);
        @(negedge clk);
        fi.req = 1; fi.size = 2; fi.addr = 32'h0000_A000;
        fd.req = 1; fd.size = 2; fd.addr = 32'h0000_B000;
        fm.addr_ok = 1; fm.data_ok = 1; fm.rdata = 32'h11;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (fm.req) begin
                ng++;
                if (fm.addr == 32'h0000_B000) nd++;
            end
            @(negedge clk);
        end
        check("fixed_grants", ng, 3);
        check("fixed_all_data", nd, 3);
        fd.req = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            if (fm.req && first == 0) first = fm.addr;
            @(negedge clk);
        end
        check("fixed_inst_after_drop", first, 32'h0000_A000);
        fi.req = 0; fm.addr_ok = 0; fm.data_ok = 0;
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] got[$];
        logic [31:0] rr_exp[3];
        bit          outst;
        logic        pv_mreq, pv_maok, pv_mdok, cur;

        clear_main();
        repeat (3) @(negedge clk);
        #2;
        check("reset_mem_req", mb.req, 0);
        check("reset_inst_addr_ok", ib.addr_ok, 0);
        check("reset_data_rdata", db.rdata, 0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);

        // Inst-only read.
        ib.req = 1; ib.wr = 0; ib.size = 2; ib.addr = 32'hBFC0_0000;
        #2 check("t1_bubble", mb.req, 0);
        @(negedge clk); #2;
        check("t1_mem_req", mb.req, 1);
        check("t1_mem_addr", mb.addr, 32'hBFC0_0000);
        @(negedge clk); mb.addr_ok = 1; #2;
        check("t1_inst_addr_ok", ib.addr_ok, 1);
        check("t1_data_addr_ok", db.addr_ok, 0);
        @(negedge clk); ib.req = 0; mb.addr_ok = 0; #2;
        check("t1_req_dropped", mb.req, 0);
        check("t1_no_early_dok", ib.data_ok, 0);
        @(negedge clk); mb.data_ok = 1; mb.rdata = 32'h3C1D_0001; #2;
        check("t1_inst_data_ok", ib.data_ok, 1);
        check("t1_inst_rdata", ib.rdata, 32'h3C1D_0001);
        check("t1_data_data_ok", db.data_ok, 0);
        @(negedge clk); mb.data_ok = 0; #2;
        check("t1_rdata_cleared", ib.rdata, 0);

        // Round-robin with both held, same-cycle addr_ok/data_ok.
        @(negedge clk);
        ib.req = 1; ib.size = 2; ib.addr = 32'h0000_1000;
        db.req = 1; db.size = 2; db.addr = 32'h0000_2000;
        mb.addr_ok = 1; mb.data_ok = 1; mb.rdata = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (mb.req) begin
                got.push_back(mb.addr);
                if (got.size() == 1) begin
                    check("t3_data_addr_ok", db.addr_ok, 1);
                    check("t3_data_data_ok", db.data_ok, 1);
                    check("t3_data_rdata", db.rdata, 32'h1234_5678);
                end
            end
            @(negedge clk);
        end
        clear_main();
        #2 check("t3_back_to_idle", mb.req, 0);
        check("rr_grant_count", got.size(), 3);
        rr_exp = '{32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
        for (int k = 0; k < 3; k++)
            check($sformatf("rr_grant_%0d", k), (k < got.size()) ? got[k] : 32'hFFFF_FFFF, rr_exp[k]);

        // Data write.
        @(negedge clk);
        db.req = 1; db.wr = 1; db.size = 2; db.addr = 32'h8000_1000; db.wdata = 32'hDEAD_BEEF;
        @(negedge clk); #2;
        check("t4_mem_req", mb.req, 1);
        check("t4_mem_wr", mb.wr, 1);
        check("t4_mem_size", mb.size, 2);
        check("t4_mem_addr", mb.addr, 32'h8000_1000);
        check("t4_mem_wdata", mb.wdata, 32'hDEAD_BEEF);
        @(negedge clk); #2 check("t4_hold_req", mb.req, 1);
        @(negedge clk); mb.addr_ok = 1; #2 check("t4_data_addr_ok", db.addr_ok, 1);
        @(negedge clk); db.req = 0; mb.addr_ok = 0; #2 check("t4_req_drops", mb.req, 0);
        @(negedge clk); mb.data_ok = 1; mb.rdata = 32'h55; #2 check("t4_data_data_ok", db.data_ok, 1);
        @(negedge clk); clear_main();

        // Spurious data_ok while idle.
        @(negedge clk); mb.data_ok = 1; mb.rdata = 32'h9999; #2;
        check("t6_no_inst_dok", ib.data_ok, 0);
        check("t6_no_data_dok", db.data_ok, 0);
        @(negedge clk); #2 check("t6_stays_idle", mb.req, 0);
        @(negedge clk); mb.data_ok = 0;

        // Async reset while in I_DATA.
        @(negedge clk); ib.req = 1; ib.size = 2; ib.addr = 32'hBFC0_0008;
        @(negedge clk); mb.addr_ok = 1;
        @(negedge clk); ib.req = 0; mb.addr_ok = 0;
        #2 mb.data_ok = 1; mb.rdata = 32'hCAFE;
        #0.5 check("t5_pre_reset_dok", ib.data_ok, 1);
        #0.5 resetn = 0;
        #1;
        check("t5_reset_dok", ib.data_ok, 0);
        check("t5_reset_rdata", ib.rdata, 0);
        check("t5_reset_mem_req", mb.req, 0);
        @(negedge clk);
        @(negedge clk); resetn = 1; #2;
        check("t5_stray_dok", ib.data_ok, 0);
        check("t5_stray_mem_req", mb.req, 0);
        @(negedge clk); mb.data_ok = 0; ib.req = 1; ib.addr = 32'hBFC0_0010;
        @(negedge clk); mb.addr_ok = 1; mb.data_ok = 1; mb.rdata = 32'h77; #2;
        check("t5_after_mem_addr", mb.addr, 32'hBFC0_0010);
        check("t5_after_addr_ok", ib.addr_ok, 1);
        check("t5_after_rdata", ib.rdata, 32'h77);
        @(negedge clk); clear_main();

        // Randomized traffic; the model-driven checker judges every cycle.
        outst = 0; pv_mreq = 0; pv_maok = 0; pv_mdok = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!(ib.req && !pv_i_aok)) begin
                if ($urandom_range(0, 2) == 0) begin
                    ib.req = 1; ib.wr = $urandom_range(0, 1); ib.size = 2'($urandom_range(0, 2));
                    ib.addr = $urandom; ib.wdata = $urandom;
                end else ib.req = 0;
            end
            if (!(db.req && !pv_d_aok)) begin
                if ($urandom_range(0, 2) == 0) begin
                    db.req = 1; db.wr = $urandom_range(0, 1); db.size = 2'($urandom_range(0, 2));
                    db.addr = $urandom; db.wdata = $urandom;
                end else db.req = 0;
            end
            if (pv_mreq && pv_maok && !pv_mdok) outst = 1;
            else if (outst && pv_mdok)          outst = 0;
            cur = (m_owner != 0) && m_wait;
            mb.rdata = $urandom;
            if (cur) begin
                mb.addr_ok = ($urandom_range(0, 1) == 0);
                mb.data_ok = mb.addr_ok ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            end else if (outst) begin
                mb.addr_ok = ($urandom_range(0, 4) == 0);
                mb.data_ok = ($urandom_range(0, 2) == 0);
            end else begin
                mb.addr_ok = ($urandom_range(0, 9) == 0);
                mb.data_ok = ($urandom_range(0, 9) == 0);
            end
            pv_mreq = cur; pv_maok = mb.addr_ok; pv_mdok = mb.data_ok;
        end
        @(negedge clk); clear_main();
        repeat (4) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
